// File: rtl/io_seg_display.sv
// io_seg_display: DMEM I/O display consumer.
// Snapshots toss_cnt / egg_cnt / is_egg_break and converts both counts to
// 4-digit BCD with one shared shift-add-3 engine (toss first, then egg).
// It then scans the result over an 8-digit active-low seven-segment display.
// Optional build macro: IO_SEG_LZ_BLANK_EN blanks leading zeros in each group.

// Per-digit glyph decode; one instance per display digit.
module io_seg_digit (
   input  logic [3:0] val,
   input  logic       blank,
   input  logic       dp,
   output logic [7:0] seg
);
   logic [6:0] glyph;

   // active-low {g,f,e,d,c,b,a} pattern for a BCD value
   always_comb begin
      glyph = 7'h7F;
      case (val)
         4'd0:    glyph = 7'h40;
         4'd1:    glyph = 7'h79;
         4'd2:    glyph = 7'h24;
         4'd3:    glyph = 7'h30;
         4'd4:    glyph = 7'h19;
         4'd5:    glyph = 7'h12;
         4'd6:    glyph = 7'h02;
         4'd7:    glyph = 7'h78;
         4'd8:    glyph = 7'h00;
         4'd9:    glyph = 7'h10;
         default: glyph = 7'h7F;
      endcase
   end

   assign seg = {~dp, blank ? 7'h7F : glyph};
endmodule

module io_seg_display #(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] toss_cnt,
   input  logic [15:0] egg_cnt,
   input  logic [15:0] is_egg_break,
   output logic [7:0]  seg,
   output logic [7:0]  an,
   output logic        conv_busy
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CONV_A = 2'd1;
   localparam logic [1:0] S_CONV_B = 2'd2;
   localparam logic [1:0] S_COMMIT = 2'd3;

   localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   // Values above 9999 would not fit in four BCD digits; show 9999 instead.
   function automatic logic [15:0] clamp9999(input logic [15:0] v);
      return (v > 16'd9999) ? 16'd9999 : v;
   endfunction

   // Add-3 correction applied to every BCD nibble of 5 or more before a shift.
   function automatic logic [15:0] add3(input logic [15:0] b);
      logic [15:0] r;
      r = b;
      for (int i = 0; i < 4; i++)
         if (r[i*4 +: 4] > 4'd4) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      return r;
   endfunction

   logic [1:0]      state;
   logic [3:0]      step;
   logic [15:0]     snap_t, snap_e, snap_b;
   logic            valid;
   logic [15:0]     bin_sr, bcd_sr, bcd_a;
   logic [15:0]     bcd_adj, bcd_next;
   logic [7:0][3:0] disp;
   logic            dp_flag;
   logic            start;
   logic [DIV_W-1:0] div;
   logic [2:0]      dig;
   logic [7:0]      blank;
   logic [7:0][7:0] seg_all;

   // A conversion is due when nothing has been shown yet or any input moved.
   assign start = !valid || (toss_cnt != snap_t) || (egg_cnt != snap_e) ||
                  (is_egg_break != snap_b);

   assign bcd_adj   = add3(bcd_sr);
   assign bcd_next  = {bcd_adj[14:0], bin_sr[15]};
   assign conv_busy = (state != S_IDLE);

   // Converter FSM: snapshot on start, 16 shifts for toss, 16 for egg, commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         step   <= '0;
         snap_t <= '0;
         snap_e <= '0;
         snap_b <= '0;
         bin_sr <= '0;
         bcd_sr <= '0;
         bcd_a  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  snap_t <= toss_cnt;
                  snap_e <= egg_cnt;
                  snap_b <= is_egg_break;
                  bin_sr <= clamp9999(toss_cnt);
                  bcd_sr <= '0;
                  step   <= '0;
                  state  <= S_CONV_A;
               end
            end
            S_CONV_A: begin
               step <= step + 4'd1;
               if (step == 4'd15) begin
                  // toss result is final; reuse the engine for egg
                  bcd_a  <= bcd_next;
                  bin_sr <= clamp9999(snap_e);
                  bcd_sr <= '0;
                  state  <= S_CONV_B;
               end else begin
                  bin_sr <= {bin_sr[14:0], 1'b0};
                  bcd_sr <= bcd_next;
               end
            end
            S_CONV_B: begin
               step   <= step + 4'd1;
               bin_sr <= {bin_sr[14:0], 1'b0};
               bcd_sr <= bcd_next;
               if (step == 4'd15) state <= S_COMMIT;
            end
            S_COMMIT: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

   // Display registers only change on COMMIT so the scan never shows partial BCD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp    <= '0;
         dp_flag <= 1'b0;
         valid   <= 1'b0;
      end else if (state == S_COMMIT) begin
         disp    <= {bcd_a, bcd_sr};
         dp_flag <= (snap_b != 16'd0);
         valid   <= 1'b1;
      end
   end

   // Free-running digit scan, independent of the converter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
         dig <= '0;
      end else if (div == DIV_LAST) begin
         div <= '0;
         dig <= dig + 3'd1;
      end else begin
         div <= div + 1'b1;
      end
   end

`ifdef IO_SEG_LZ_BLANK_EN
   // A digit blanks when it and all higher digits of its group are zero;
   // units digits (4 and 0) always show.
   always_comb begin
      blank    = '0;
      blank[7] = (disp[7] == 4'd0);
      blank[6] = blank[7] && (disp[6] == 4'd0);
      blank[5] = blank[6] && (disp[5] == 4'd0);
      blank[3] = (disp[3] == 4'd0);
      blank[2] = blank[3] && (disp[2] == 4'd0);
      blank[1] = blank[2] && (disp[1] == 4'd0);
   end
`else
   assign blank = '0;
`endif

   for (genvar i = 0; i < 8; i++) begin : g_dig
      io_seg_digit u_dig (
         .val   (disp[i]),
         .blank (blank[i]),
         .dp    ((i < 4) ? dp_flag : 1'b0),
         .seg   (seg_all[i])
      );
   end

   // Registered pin drivers; display stays dark until the first commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= 8'hFF;
         an  <= 8'hFF;
      end else if (!valid) begin
         seg <= 8'hFF;
         an  <= 8'hFF;
      end else begin
         seg <= seg_all[dig];
         an  <= ~(8'h01 << dig);
      end
   end
endmodule

// File: doc/io_seg_display.md
# io_seg_display

Memory-mapped display consumer for the data-memory I/O window. It takes the `toss_cnt`, `egg_cnt` and `is_egg_break` registers that the CPU writes through DMEM stores, and converts both counts to decimal with an iterative shift-add-3 converter. It then drives an 8-digit multiplexed seven-segment display. It sits between the DMEM I/O register outputs and the board display pins, on the CPU clock.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clock cycles each digit stays enabled; legal range ≥ 2.

Ports:
- `clk`  in  1  CPU clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `toss_cnt`  in  16  binary value shown on digits 7..4, unsigned.
- `egg_cnt`  in  16  binary value shown on digits 3..0, unsigned.
- `is_egg_break`  in  16  nonzero lights the decimal points of digits 3..0.
- `seg`  out  8  active-low segments `{dp,g,f,e,d,c,b,a}`.
- `an`  out  8  active-low one-hot digit enable; bit 0 is the rightmost digit.
- `conv_busy`  out  1  high while the converter FSM is not in IDLE.

## Operation
- Snapshot registers `snap_t`, `snap_e`, `snap_b` hold the values last accepted for conversion.
- The `valid` flag clears on reset and sets on the first COMMIT.
- FSM states:
  - IDLE: a conversion starts if `!valid`, or if any input differs from its snapshot. Starting loads all three snapshots and goes to CONV_A.
  - CONV_A: converts the clamped `snap_t` in 16 shift-add-3 steps, then goes to CONV_B.
  - CONV_B: converts the clamped `snap_e` the same way, then goes to COMMIT.
  - COMMIT: copies the 8 BCD digits and the dp flag (`snap_b != 0`) into the display registers, sets `valid`, and returns to IDLE.
- Clamping: a value above 9999 converts as 9999. Only 4 BCD digits are kept per value.
- Input changes during CONV_A, CONV_B or COMMIT are ignored. They are caught in the next IDLE cycle by the snapshot compare.
- Scan:
  - `div` counts 0..SCAN_DIV-1.
  - On wrap, `dig` (3 bits) increments modulo 8.
  - `an = ~(1<<dig)`.
  - `seg` is the registered decode of display digit `dig`.
- Digit encoding, active-low on `seg[6:0]`:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
- `seg[7]` is 0 only when `dig` ≤ 3 and the dp flag is set.
- While `valid` = 0, `an` = FF and `seg` = FF.

## Timing
- Reset values: `seg` = FF, `an` = FF, `conv_busy` = 0, `div` = 0, `dig` = 0, FSM in IDLE, display digits 0, dp 0, `valid` = 0, snapshots 0.
- Change accepted at edge E0, when the FSM is in IDLE:
  - E1..E16: CONV_A shifts.
  - E17..E32: CONV_B shifts.
  - E33: COMMIT writes the display registers.
  - Total latency from input change to display-register update is 33 cycles. `conv_busy` is high from after E0 through E33.
- After reset deassertion, the first conversion starts at the first edge. It commits 0000/0000 at edge 34.
- `seg` and `an` are registered. They change one cycle after a `dig` or display-register update.
- Reset mid-conversion aborts immediately. All state returns to reset values, and the display blanks until a fresh conversion commits.
- The scan counter runs independently of the FSM. A commit never resets `div` or `dig`.

## Configuration
- `IO_SEG_LZ_BLANK_EN` defined: leading zeros are blanked, meaning `seg[6:0]` = 7F for those digits.
  - Blankable digits are 7..5 of the toss group and 3..1 of the egg group.
  - A digit is blank when it and every more-significant digit in its group are 0.
  - Units digits 4 and 0 are never blanked.
  - dp behaviour is unchanged.
- Not defined: all digits are shown, including leading zeros.

## Test plan
- Reset, then release with all inputs 0 and SCAN_DIV=4 → `an`/`seg` stay FF until commit at edge 34, then `an` cycles FE,FD,…,7F, each for 4 cycles, with `seg` = C0.
- `toss_cnt`=1234, `egg_cnt`=56 → `conv_busy` is high for 33 cycles. Digits 7..0 read 1,2,3,4,0,0,5,6, i.e. `seg` F9,A4,B0,99,C0,C0,92,82.
- `toss_cnt`=65535, `egg_cnt`=10000 → every digit shows 9, `seg` = 90.
- `is_egg_break`=1 with counts unchanged → reconversion runs. Digits 3..0 then show dp low (`seg[7]`=0) and digits 7..4 keep `seg[7]`=1.
- Change `egg_cnt` 5→7 at CONV_A cycle 3 → the display first commits 5. At the next IDLE a second conversion starts, and 7 commits 33 cycles later.
- With `IO_SEG_LZ_BLANK_EN`, `toss_cnt`=7, `egg_cnt`=0 → digits 7..5 and 3..1 have `seg` = FF, digit 4 = F8, digit 0 = C0. Additionally, asserting `rst_n`=0 mid-CONV_B returns all outputs to reset values asynchronously.
